// File: rtl/odd_p_tx_4bit.sv
// Odd-parity serial transmitter: accepts one nibble per valid/ready handshake and
// sends start, 4 data bits LSB first, odd parity and stop, CLKS_PER_BIT cycles each.
module odd_p_tx_4bit #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       p,
  output logic       busy
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       shift_q, shift_d;
  logic             p_q, p_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             bit_end;

  assign ready   = (state_q == S_IDLE) && !rst;
  assign accept  = valid && ready;
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    p_d     = p_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = i;
          p_d     = ~^i;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 2'd3) begin
            state_d = S_PARITY;
          end else begin
            idx_d   = idx_q + 2'd1;
            shift_d = {1'b0, shift_q[3:1]};
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the upcoming state.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = p_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign tx   = tx_q;
  assign p    = p_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_odd_p_tx_4bit.sv
// Directed bench for odd_p_tx_4bit: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_odd_p_tx_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i4, i1;
  logic       valid4, valid1;
  logic       ready4, tx4, p4, busy4;
  logic       ready1, tx1, p1, busy1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  odd_p_tx_4bit #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .i(i4), .valid(valid4),
    .ready(ready4), .tx(tx4), .p(p4), .busy(busy4)
  );

  odd_p_tx_4bit #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .i(i1), .valid(valid1),
    .ready(ready1), .tx(tx1), .p(p1), .busy(busy1)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference frame bit n of nibble d: start, d[0..3], odd parity, stop.
  function automatic logic frame_bit(input logic [3:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n >= 1 && n <= 4) return d[n-1];
    if (n == 5) return ~(d[0] ^ d[1] ^ d[2] ^ d[3]);
    return 1'b1;
  endfunction

  // Send one nibble on the 4-clock instance and check the whole frame.
  task automatic frame4(input string name, input logic [3:0] d,
                        input logic [6:0] exp_bits, input logic exp_p);
    check($sformatf("%s ready_before", name), ready4, 1'b1);
    i4 = d;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    check($sformatf("%s p", name), p4, exp_p);
    check($sformatf("%s busy", name), busy4, 1'b1);
    for (int b = 0; b < 7; b++) begin
      for (int c = 0; c < 4; c++) begin
        i4 = 4'($urandom_range(0, 15));
        check($sformatf("%s tx bit%0d c%0d", name, b, c), tx4, exp_bits[b]);
        check($sformatf("%s ready_low bit%0d c%0d", name, b, c), ready4, 1'b0);
        step();
      end
    end
    check($sformatf("%s ready_after", name), ready4, 1'b1);
    check($sformatf("%s busy_after", name), busy4, 1'b0);
    check($sformatf("%s tx_idle", name), tx4, 1'b1);
  endtask

  logic [6:0] bits;
  logic [3:0] acc_d;
  int         acc_t;
  logic       exp_tx;
  logic       exp_rdy;

  initial begin
    rst = 1'b1; valid4 = 1'b0; valid1 = 1'b0; i4 = 4'd0; i1 = 4'd0;
    #1;
    check("reset ready4_low", ready4, 1'b0);
    check("reset ready1_low", ready1, 1'b0);
    step();
    step();
    check("reset tx4", tx4, 1'b1);
    check("reset p4", p4, 1'b0);
    check("reset busy4", busy4, 1'b0);
    check("reset tx1", tx1, 1'b1);
    check("reset busy1", busy1, 1'b0);
    rst = 1'b0;
    #1;
    check("post_reset ready4", ready4, 1'b1);
    check("post_reset ready1", ready1, 1'b1);
    step();

    // Hand-computed frames: bit 0 is start, bit 6 is stop.
    frame4("n0000", 4'b0000, 7'b1100000, 1'b1);
    frame4("n1011", 4'b1011, 7'b1010110, 1'b0);

    // All nibbles at one clock per bit, decoded by the bench.
    for (int n = 0; n < 16; n++) begin
      check($sformatf("c1 n%0d ready", n), ready1, 1'b1);
      i1 = 4'(n);
      valid1 = 1'b1;
      step();
      valid1 = 1'b0;
      i1 = ~4'(n);
      check($sformatf("c1 n%0d p", n), p1, ~(^(4'(n))));
      for (int b = 0; b < 7; b++) begin
        bits[b] = tx1;
        step();
      end
      check($sformatf("c1 n%0d start", n), bits[0], 1'b0);
      check($sformatf("c1 n%0d data", n), (bits[4:1] === 4'(n)), 1'b1);
      check($sformatf("c1 n%0d odd", n), ^bits[5:1], 1'b1);
      check($sformatf("c1 n%0d stop", n), bits[6], 1'b1);
    end
    check("c1 ready_end", ready1, 1'b1);

    // valid held high with i changing every cycle: two back-to-back frames.
    for (int t = 0; t <= 58; t++) begin
      i4 = 4'(t * 7 + 3);
      valid4 = (t != 58);
      exp_rdy = (t == 0 || t == 29 || t == 58);
      acc_t = (t < 29) ? 0 : 29;
      acc_d = 4'(acc_t * 7 + 3);
      exp_tx = exp_rdy ? 1'b1 : frame_bit(acc_d, (t - acc_t - 1) / 4);
      check($sformatf("b2b t%0d ready", t), ready4, exp_rdy);
      check($sformatf("b2b t%0d tx", t), tx4, exp_tx);
      step();
    end
    valid4 = 1'b0;
    check("b2b idle_after", busy4, 1'b0);

    // Reset pulse while sending data bit 2.
    check("rst_mid ready_before", ready4, 1'b1);
    i4 = 4'b1010;
    valid4 = 1'b1;
    step();
    valid4 = 1'b0;
    for (int c = 0; c < 13; c++) step();
    rst = 1'b1;
    #1;
    check("rst_mid tx_bit2", tx4, 1'b0);
    check("rst_mid busy_before", busy4, 1'b1);
    check("rst_mid p_before", p4, 1'b1);
    check("rst_mid ready_in_rst", ready4, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("rst_mid tx", tx4, 1'b1);
    check("rst_mid busy", busy4, 1'b0);
    check("rst_mid p", p4, 1'b0);
    check("rst_mid ready", ready4, 1'b1);
    step();
    frame4("n0110", 4'b0110, 7'b1101100, 1'b1);

    // rst and valid together: no transfer.
    rst = 1'b1;
    valid4 = 1'b1;
    i4 = 4'b0111;
    #1;
    check("rst_valid ready", ready4, 1'b0);
    step();
    rst = 1'b0;
    valid4 = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("rst_valid tx c%0d", c), tx4, 1'b1);
      check($sformatf("rst_valid busy c%0d", c), busy4, 1'b0);
      step();
    end
    check("rst_valid ready_end", ready4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
